tt_um_spi_ram_reader: RTL and testbench
=======================================

# tt_um_spi_ram_reader

Tiny Tapeout user module that acts as an SPI master and continuously reads one byte from an external 256-byte SPI SRAM. The address comes from `ui_in`; the byte read is presented on `uo_out`. SPI pins sit on the bidirectional `uio` bus: CS_N, MOSI and SCK are outputs, and MISO is an input.

## Interface
- `CMD_READ`, 8'h03: SPI read opcode sent first in every frame.
- `ADDR_BITS`, 8: address width. The frame is opcode, then address, then one data byte.
- `clk` input 1: sole clock; all logic on its rising edge.
- `rst` input 1: synchronous reset, active-high.
- `ena` input 1: enable. When low, no new transaction starts.
- `ui_in` input 8: read address.
- `uo_out` output 8: last byte read.
- `uio_in` input 8: bit 2 = MISO; other bits ignored.
- `uio_out` output 8: bit 0 = CS_N, bit 1 = MOSI, bit 3 = SCK; all other bits 0.
- `uio_oe` output 8: constant 8'b0000_1011.

## Operation
- SPI mode 0:
  - SCK idles low.
  - MOSI changes only while SCK is low.
  - The slave samples on SCK rising; the slave drives MISO after SCK falling.
- SCK runs at clk/2 and is a registered output.
- Frame: CS_N low, then 24 SCK pulses, then CS_N high.
  - Bits 1–8: `CMD_READ`, MSB first.
  - Bits 9–16: address, MSB first.
  - Bits 17–24: data byte clocked in from MISO, MSB first. MOSI = 0 during this phase.
- States:
  - IDLE → START when `ena`=1.
  - START: latch `ui_in` into the TX shift register together with the opcode. Assert CS_N. Drive MOSI = bit 23.
  - SHIFT alternates HIGH and LOW phases:
    - HIGH phase sets SCK=1.
    - LOW phase sets SCK=0, shifts the next TX bit onto MOSI, and, during the data phase, shifts MISO into the RX register.
  - A 5-bit counter advances once per completed SCK pulse.
  - After the 24th pulse → DONE.
  - DONE: release CS_N, load RX byte into `uo_out`, pulse internal `done` for one cycle → IDLE.
- Transactions repeat back-to-back while `ena`=1, so `uo_out` tracks `ui_in` with one-frame lag.
- `ui_in` changes mid-frame do not affect the current frame; the address is latched at START.
- `ena` falling mid-frame: the current frame completes normally. No new START follows.
- Reset at any point, including mid-frame:
  - CS_N=1, SCK=0, MOSI=0, `uo_out`=8'h00, `done`=0.
  - Shift registers and counter cleared. State = IDLE.
- The RAM always returns data for the 8-bit address; there is no wrap or error handling in the DUT.

## Timing
- Clock edge E0 = START (CS_N falls, MOSI = bit 23).
- SCK rises at E(2k−1) and falls at E(2k), for k = 1..24.
- MISO is sampled at the edges where SCK goes low: E34, E36, …, E48.
- E48: last pulse ends.
- E49: CS_N high, `uo_out` updated, `done`=1 for exactly one cycle.
- Read latency from START to valid `uo_out` = 49 clk.
- CS_N stays high for at least 2 clk (DONE + IDLE) before the next START.
- Reset values: `uo_out`=0x00, `uio_out`=0x01 (CS_N high), `uio_oe`=0x0B.

## Structure
- Shared package: `CMD_READ`, `ADDR_BITS`, frame length (24), SPI pin indices (0, 1, 2, 3), `UIO_OE` constant.
- One sub-module `spi_if`:
  - Inputs: `start`, 8-bit `addr`, `miso`.
  - Outputs: `cs_n`, `sck`, `mosi`, 8-bit `rdata`, `done`.
  - Contains the FSM and shift registers.
- The top is pin mapping, the `ena` gating/restart logic and the `uo_out` register.
- Verification uses a behavioral `spi_ram_model`, not part of RTL:
  - Parameter `MEM_BYTES`=256; pins `cs_n`, `sck`, `mosi`, `miso`.
  - Decodes 0x03 + address and shifts out `mem[addr]` on SCK falling edges.
  - MISO = 0 when deselected.

## Test plan
- Reset held 3 clk → `uo_out`=0x00, CS_N=1, SCK=0, `uio_oe`=0x0B; no SCK activity while `ena`=0.
- `mem[0x12]`=0xA5, `ui_in`=0x12, `ena`=1 → MOSI carries 0x03 then 0x12, exactly 24 SCK pulses, `done` pulse, `uo_out`=0xA5 at E49.
- Boundary addresses: `mem[0x00]`=0x5A, `mem[0xFF]`=0xC3 → respective reads give 0x5A and 0xC3.
- `ui_in` switched from 0x12 to 0x34 mid-frame (`mem[0x34]`=0x0F) → current frame returns 0xA5, the next returns 0x0F.
- `rst` asserted at pulse 10 → next edge CS_N=1, SCK=0, `uo_out`=0x00; after release, a fresh full 24-pulse frame starts.
- `ena` dropped mid-frame → frame completes, `uo_out` updates once, then CS_N stays high.

Source files
------------

// File: rtl/tt_um_spi_ram_reader_pkg.sv
// Shared constants and types for the SPI RAM reader: opcode, frame geometry,
// uio pin map and the SPI master state encoding.
package tt_um_spi_ram_reader_pkg;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam int         ADDR_BITS  = 8;
  localparam int         FRAME_BITS = 24;
  localparam int         CNT_W      = 5;

  // Pulse counts (before increment) that matter inside a frame.
  localparam logic [CNT_W-1:0] CNT_DATA = 5'd16;
  localparam logic [CNT_W-1:0] CNT_LAST = 5'd23;

  localparam int PIN_CS_N = 0;
  localparam int PIN_MOSI = 1;
  localparam int PIN_MISO = 2;
  localparam int PIN_SCK  = 3;

  localparam logic [7:0] UIO_OE = 8'b0000_1011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_HIGH,
    ST_LOW,
    ST_DONE
  } spi_state_e;

  // Full outgoing frame: opcode, address, then zeros while the slave talks.
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [ADDR_BITS-1:0] addr);
    return {CMD_READ, addr, 8'h00};
  endfunction

endpackage

// File: rtl/tt_um_spi_ram_reader_spi_if.sv
// SPI mode-0 master that runs one 24-bit read frame (opcode, address, data)
// per start request; SCK is clk/2 and every pin is driven from a flop.
module spi_if
  import tt_um_spi_ram_reader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 miso,
  output logic                 cs_n,
  output logic                 sck,
  output logic                 mosi,
  output logic [7:0]           rdata,
  output logic                 done
);

  spi_state_e            state_q, state_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [7:0]            rx_q, rx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value; the combinational block below uses blocking (=).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a hold default first, so no path infers a latch.
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    cs_n_d  = cs_n_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_START;
      end
      ST_START: begin
        tx_d    = frame_word(addr);
        rx_d    = '0;
        cnt_d   = '0;
        cs_n_d  = 1'b0;
        mosi_d  = tx_d[FRAME_BITS-1];
        state_d = ST_HIGH;
      end
      ST_HIGH: begin
        sck_d   = 1'b1;
        state_d = ST_LOW;
      end
      ST_LOW: begin
        // Falling SCK: present the next bit and capture the slave's bit.
        sck_d  = 1'b0;
        tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
        mosi_d = tx_q[FRAME_BITS-2];
        if (cnt_q >= CNT_DATA) rx_d = {rx_q[6:0], miso};
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_q == CNT_LAST) ? ST_DONE : ST_HIGH;
      end
      ST_DONE: begin
        cs_n_d  = 1'b1;
        mosi_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cs_n  = cs_n_q;
  assign sck   = sck_q;
  assign mosi  = mosi_q;
  assign rdata = rx_q;
  assign done  = (state_q == ST_DONE);

endmodule

// File: rtl/tt_um_spi_ram_reader.sv
// Tiny Tapeout wrapper: maps the SPI master onto uio, restarts frames while
// ena is high and holds the last byte read on uo_out.
module tt_um_spi_ram_reader
  import tt_um_spi_ram_reader_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst
);

  logic       spi_cs_n;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_done;
  logic [7:0] spi_rdata;
  logic [7:0] uo_out_q;
  logic       unused_uio_in;

  assign unused_uio_in = &{1'b0, uio_in[7:3], uio_in[1:0]};

  // A frame in flight always finishes; ena is only looked at from IDLE.
  spi_if u_spi (
    .clk   (clk),
    .rst   (rst),
    .start (ena),
    .addr  (ui_in),
    .miso  (uio_in[PIN_MISO]),
    .cs_n  (spi_cs_n),
    .sck   (spi_sck),
    .mosi  (spi_mosi),
    .rdata (spi_rdata),
    .done  (spi_done)
  );

  always_ff @(posedge clk) begin
    if (rst)           uo_out_q <= 8'h00;
    else if (spi_done) uo_out_q <= spi_rdata;
  end

  always_comb begin
    uio_out           = 8'h00;
    uio_out[PIN_CS_N] = spi_cs_n;
    uio_out[PIN_MOSI] = spi_mosi;
    uio_out[PIN_SCK]  = spi_sck;
  end

  assign uo_out = uo_out_q;
  assign uio_oe = UIO_OE;

endmodule

// File: tb/tb_tt_um_spi_ram_reader.sv
// Directed bench for tt_um_spi_ram_reader with a behavioural 256-byte SPI RAM
// that decodes opcode 0x03 + address and shifts data out on SCK falling edges.
module tb_tt_um_spi_ram_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tt_um_spi_ram_reader dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst     (rst)
  );

  // ---------------- spi_ram_model (MEM_BYTES = 256) ----------------
  logic [7:0]  mem [0:255];
  logic        cs_n, sck, mosi, miso;
  logic [4:0]  m_cnt;
  logic [15:0] m_sh;
  logic [7:0]  m_byte;
  logic        miso_q;

  assign cs_n   = uio_out[0];
  assign mosi   = uio_out[1];
  assign sck    = uio_out[3];
  assign miso   = cs_n ? 1'b0 : miso_q;
  assign uio_in = {5'b0, miso, 2'b0};

  always @(posedge sck or posedge cs_n) begin
    if (cs_n) begin
      m_cnt <= 5'd0;
      m_sh  <= 16'h0;
    end else begin
      m_cnt <= m_cnt + 5'd1;
      m_sh  <= {m_sh[14:0], mosi};
    end
  end

  always @(negedge sck or posedge cs_n) begin
    if (cs_n) begin
      miso_q <= 1'b0;
      m_byte <= 8'h00;
    end else if (m_cnt == 5'd16) begin
      if (m_sh[15:8] == 8'h03) begin
        miso_q <= mem[m_sh[7:0]][7];
        m_byte <= {mem[m_sh[7:0]][6:0], 1'b0};
      end else begin
        miso_q <= 1'b0;
        m_byte <= 8'h00;
      end
    end else if (m_cnt > 5'd16) begin
      miso_q <= m_byte[7];
      m_byte <= {m_byte[6:0], 1'b0};
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for CS_N to fall; n = edges waited, ok = frame started.
  task automatic wait_cs_low(output int n, output bit ok);
    n = 0;
    while (uio_out[0] && n < 40) begin
      tick();
      n++;
    end
    ok = !uio_out[0];
  endtask

  // Runs one frame from CS_N falling (E0) to CS_N rising; optionally changes
  // ui_in / drops ena at a given cycle inside the frame.
  task automatic run_frame(input string tag, input logic [7:0] exp_addr,
                           input logic [7:0] exp_data, input int exp_gap,
                           input int chg_cycle, input logic [7:0] chg_addr,
                           input bit drop_ena);
    int n, cyc, pulses, dones;
    bit ok;
    logic prev_sck;
    logic [23:0] word;
    wait_cs_low(n, ok);
    if (!ok) begin
      check({tag, "_start"}, 32'(uio_out[0]), 32'd0);
      return;
    end
    if (exp_gap != 0) check({tag, "_gap"}, n, exp_gap);
    cyc = 0; pulses = 0; dones = 0; word = '0; prev_sck = uio_out[3];
    while (!uio_out[0] && cyc < 80) begin
      tick();
      cyc++;
      if (uio_out[3] && !prev_sck) begin
        pulses++;
        word = {word[22:0], uio_out[1]};
      end
      prev_sck = uio_out[3];
      if (dut.spi_done) dones++;
      if (cyc == chg_cycle) begin
        ui_in = chg_addr;
        if (drop_ena) ena = 1'b0;
      end
    end
    check({tag, "_latency"}, cyc, 49);
    check({tag, "_pulses"}, pulses, 24);
    check({tag, "_mosi"}, word, {8'h03, exp_addr, 8'h00});
    check({tag, "_done"}, dones, 1);
    check({tag, "_uo_out"}, uo_out, exp_data);
  endtask

  initial begin
    int n, sck_rises;
    bit ok;
    logic prev;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h12] = 8'hA5;
    mem[8'h00] = 8'h5A;
    mem[8'hFF] = 8'hC3;
    mem[8'h34] = 8'h0F;

    rst = 1'b1; ena = 1'b0; ui_in = 8'h00;
    repeat (3) tick();
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h01);
    check("rst_uio_oe", uio_oe, 8'h0B);

    rst = 1'b0;
    sck_rises = 0; prev = uio_out[3]; n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (uio_out[3] && !prev) sck_rises++;
      if (!uio_out[0]) n++;
      prev = uio_out[3];
    end
    check("idle_sck_pulses", sck_rises, 0);
    check("idle_cs_low_cycles", n, 0);

    ui_in = 8'h12; ena = 1'b1;
    run_frame("rd12", 8'h12, 8'hA5, 0, 0, 8'h00, 1'b0);
    ui_in = 8'h00;
    run_frame("rd00", 8'h00, 8'h5A, 2, 0, 8'h00, 1'b0);
    ui_in = 8'hFF;
    run_frame("rdff", 8'hFF, 8'hC3, 2, 0, 8'h00, 1'b0);
    ui_in = 8'h12;
    run_frame("midchg", 8'h12, 8'hA5, 2, 20, 8'h34, 1'b0);
    run_frame("next34", 8'h34, 8'h0F, 2, 0, 8'h00, 1'b0);

    // Reset during pulse 10 (SCK rises at E19), applied at E20.
    wait_cs_low(n, ok);
    check("rstmid_start", 32'(ok), 32'd1);
    repeat (19) tick();
    check("rstmid_sck_high", uio_out[3], 1'b1);
    rst = 1'b1;
    tick();
    check("rstmid_uio_out", uio_out, 8'h01);
    check("rstmid_uo_out", uo_out, 8'h00);
    tick();
    rst = 1'b0;
    run_frame("rst_recover", 8'h34, 8'h0F, 0, 0, 8'h00, 1'b0);

    ui_in = 8'hFF;
    run_frame("ena_drop", 8'hFF, 8'hC3, 2, 20, 8'h00, 1'b1);
    n = 0; sck_rises = 0; prev = uio_out[3];
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!uio_out[0]) n++;
      if (uio_out[3] && !prev) sck_rises++;
      prev = uio_out[3];
    end
    check("ena_drop_cs_low_cycles", n, 0);
    check("ena_drop_sck_pulses", sck_rises, 0);
    check("ena_drop_uo_hold", uo_out, 8'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
